// File: rtl/dac_snapshot_pkg.sv
// Shared types and helpers for the DAC snapshot capture block: FSM encoding,
// RAM depth derivation and the capture-length clamp.
package dac_snapshot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH    = 128;
  localparam int DEF_DEPTH_LOG2    = 10;
  localparam int DEF_PRETRIG_BEATS = 64;

  function automatic int unsigned depth_of(input int unsigned log2);
    return 32'd1 << log2;
  endfunction

  // A zero or oversized request means "as many beats as fit".
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
    return (req == 0 || req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/dac_snapshot_capture_if.sv
// DAC sample bus, capture control, readback and status signals of the snapshot block.
// slave = the capture block, master = whoever drives the TX data and control.
interface dac_snapshot_capture_if
  import dac_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);
  logic [DATA_WIDTH-1:0] dac_data_in;
  logic [DATA_WIDTH-1:0] dac_data_out;
  logic                  arm;
  logic                  trigger;
  logic [DEPTH_LOG2:0]   capture_len;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  armed;
  logic                  busy;
  logic                  done;
  logic [DEPTH_LOG2-1:0] start_addr;

  modport slave (
    input  dac_data_in, arm, trigger, capture_len, rd_en, rd_addr,
    output dac_data_out, rd_data, rd_valid, armed, busy, done, start_addr
  );

  modport master (
    output dac_data_in, arm, trigger, capture_len, rd_en, rd_addr,
    input  dac_data_out, rd_data, rd_valid, armed, busy, done, start_addr
  );
endinterface

// File: rtl/dac_snapshot_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port (latency 1).
// Only the read register is reset; the array is left uninitialised so it maps to block RAM.
module dac_snapshot_ram
  import dac_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int DEPTH = int'(depth_of(DEPTH_LOG2));

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dac_snapshot_capture.sv
// DAC bus pass-through (1 cycle, never stalls) plus arm/trigger snapshot into RAM, read back in DONE.
// Build option DAC_SNAPSHOT_PRETRIG_EN keeps a circular pre-trigger history while ARMED.
module dac_snapshot_capture
  import dac_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2    = DEF_DEPTH_LOG2,
  parameter int PRETRIG_BEATS = DEF_PRETRIG_BEATS
) (
  input logic                   clock,
  input logic                   resetn,
  dac_snapshot_capture_if.slave bus
);
  localparam int DEPTH = int'(depth_of(DEPTH_LOG2));
  localparam int AW    = DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
`ifdef DAC_SNAPSHOT_PRETRIG_EN
  localparam logic PRE_EN  = 1'b1;
  localparam int   MAX_LEN = DEPTH - PRETRIG_BEATS;
`else
  localparam logic PRE_EN  = 1'b0;
  localparam int   MAX_LEN = DEPTH;
`endif

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_cnt;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_waddr;
  logic [AW-1:0]         r_start;
  logic                  r_we;
  logic                  r_rd_valid;
  logic                  w_log_we;
  logic                  w_arm_evt;
  logic                  w_trig_evt;
  logic                  w_rd_go;
  logic [AW-1:0]         w_pre_start;

  // The beat at r_wptr is the current dac_data_in; it reaches the RAM one cycle later
  // from r_dout, so CAPTURE spans exactly len cycles with the trigger beat first.
  always_comb begin
    w_state_nxt = r_state;
    w_log_we    = 1'b0;
    w_arm_evt   = 1'b0;
    w_trig_evt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.arm) begin
          w_state_nxt = ST_ARMED;
          w_arm_evt   = 1'b1;
        end
      end
      ST_ARMED: begin
        w_log_we = bus.trigger | PRE_EN;
        if (bus.trigger) begin
          w_state_nxt = ST_CAPTURE;
          w_trig_evt  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_log_we = (r_cnt < r_len);
        if (r_cnt == r_len) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.arm) begin
          w_state_nxt = ST_ARMED;
          w_arm_evt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rd_go     = bus.rd_en && (r_state == ST_DONE);
  assign w_pre_start = r_wptr - AW'(PRETRIG_BEATS);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_dout     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_waddr    <= '0;
      r_start    <= '0;
      r_we       <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dout     <= bus.dac_data_in;
      r_we       <= w_log_we;
      r_waddr    <= r_wptr;
      r_rd_valid <= w_rd_go;
      if (w_arm_evt) begin
        r_len  <= LW'(clamp_len(32'(bus.capture_len), MAX_LEN));
        r_wptr <= '0;
        r_cnt  <= '0;
      end else if (w_log_we) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_trig_evt) begin
        r_cnt   <= LW'(1);
        r_start <= PRE_EN ? w_pre_start : '0;
      end else if (w_log_we && r_state == ST_CAPTURE) begin
        r_cnt <= r_cnt + LW'(1);
      end
    end
  end

  dac_snapshot_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .resetn  (resetn),
    .i_we    (r_we),
    .i_waddr (r_waddr),
    .i_wdata (r_dout),
    .i_re    (w_rd_go),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data)
  );

  assign bus.dac_data_out = r_dout;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.armed        = (r_state == ST_ARMED);
  assign bus.busy         = (r_state == ST_CAPTURE);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.start_addr   = r_start;
endmodule

// File: tb/tb_dac_snapshot_capture.sv
// Directed bench for dac_snapshot_capture; expectations adapt when DAC_SNAPSHOT_PRETRIG_EN is defined.
// Input beat in cycle n is pat(n), so every expected RAM word follows from the trigger cycle.
module tb_dac_snapshot_capture;
  localparam int DW    = 128;
  localparam int AL    = 10;
  localparam int DEPTH = 1024;
`ifdef DAC_SNAPSHOT_PRETRIG_EN
  localparam int PRE  = 64;
  localparam int MAXL = 960;
`else
  localparam int PRE  = 0;
  localparam int MAXL = 1024;
`endif

  logic clock = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clock = ~clock;

  dac_snapshot_capture_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(AL)) bus ();

  dac_snapshot_capture #(
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (AL),
    .PRETRIG_BEATS (64)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] u;
    u = k;
    return {u ^ 32'hDEAD_BEEF, u, ~u, u * 32'd3};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, {bus.armed, bus.busy, bus.done}, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    bus.dac_data_in = pat(cyc);
  endtask

  // Arm, wait, trigger, measure CAPTURE length, then read back [first_i..last_i] and the last beat.
  task automatic run_capture(input string tag, input int len_req, input int wait_cyc,
                             input int exp_len, input int first_i, input int last_i);
    int trig_k;
    int taddr;
    int nb;
    bus.capture_len = (AL+1)'(len_req);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk_st({tag, "_armed"}, 3'b100);
    repeat (wait_cyc) tick();
    bus.trigger = 1'b1;
    trig_k = cyc;
    tick();
    bus.trigger = 1'b0;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 3000) begin
      nb++;
      tick();
    end
    chk({tag, "_busy_cycles"}, nb, exp_len);
    chk_st({tag, "_done"}, 3'b001);
    taddr = (PRE != 0) ? wait_cyc : 0;
    chk({tag, "_start_addr"}, bus.start_addr, (taddr - PRE + DEPTH) % DEPTH);
    for (int i = first_i; i <= last_i; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AL'((taddr + i + DEPTH) % DEPTH);
      tick();
      chk({tag, "_rd_valid"}, bus.rd_valid, 1'b1);
      chk({tag, "_rd_data"}, bus.rd_data, pat(trig_k + i));
    end
    bus.rd_addr = AL'((taddr + exp_len - 1) % DEPTH);
    tick();
    chk({tag, "_rd_last"}, bus.rd_data, pat(trig_k + exp_len - 1));
    bus.rd_en = 1'b0;
    tick();
    chk({tag, "_rd_valid_off"}, bus.rd_valid, 1'b0);
  endtask

  initial begin
    int nb;
    int trig_k;
    int taddr;
    resetn          = 1'b0;
    bus.dac_data_in = '0;
    bus.arm         = 1'b0;
    bus.trigger     = 1'b0;
    bus.capture_len = '0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;

    // Reset state and 1-cycle pass-through
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dout", bus.dac_data_out, '0);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk_st("rst_status", 3'b000);
    chk("rst_start", bus.start_addr, '0);
    resetn = 1'b1;
    bus.dac_data_in = pat(cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("passthru", bus.dac_data_out, pat(cyc - 1));
    end
    chk_st("passthru_status", 3'b000);

    // Basic capture, full-depth via 0 and via oversize, then a pre-trigger sized window
    run_capture("len16", 16, 5, 16, 0, 15);
    run_capture("len0", 0, 0, MAXL, 0, 3);
    run_capture("len2000", 2000, 3, MAXL, 0, 3);
    run_capture("len32", 32, 200, 32, -PRE, 31);

    // Reset in the middle of a capture
    bus.capture_len = 11'd16;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    repeat (6) tick();
    chk_st("midcap_busy", 3'b010);
    resetn = 1'b0;
    #1;
    chk("midrst_dout", bus.dac_data_out, '0);
    chk("midrst_rd_data", bus.rd_data, '0);
    chk_st("midrst_status", 3'b000);
    chk("midrst_start", bus.start_addr, '0);
    tick();
    resetn = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("postrst_rd_valid", bus.rd_valid, 1'b0);
    chk("postrst_rd_data", bus.rd_data, '0);
    chk_st("postrst_status", 3'b000);

    // Ignored events: trigger in IDLE, arm+trigger together, arm/trigger during CAPTURE
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk_st("idle_trig", 3'b000);
    bus.capture_len = 11'd8;
    bus.arm = 1'b1;
    bus.trigger = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.trigger = 1'b0;
    chk_st("arm_trig_same", 3'b100);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("armed_rd_valid", bus.rd_valid, 1'b0);
    chk_st("still_armed", 3'b100);
    bus.capture_len = 11'd3;
    bus.trigger = 1'b1;
    trig_k = cyc;
    tick();
    bus.trigger = 1'b0;
    chk_st("ign_cap_start", 3'b010);
    tick();
    bus.arm = 1'b1;
    bus.trigger = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.trigger = 1'b0;
    chk_st("ign_arm_in_cap", 3'b010);
    chk("cap_passthru", bus.dac_data_out, pat(cyc - 1));
    nb = 2;
    while (bus.busy === 1'b1 && nb < 3000) begin
      nb++;
      tick();
    end
    chk("ign_busy_cycles", nb, 8);
    chk_st("ign_done", 3'b001);
    taddr = (PRE != 0) ? 1 : 0;
    bus.rd_en = 1'b1;
    bus.rd_addr = AL'(taddr);
    tick();
    chk("ign_rd_first", bus.rd_data, pat(trig_k));
    bus.rd_addr = AL'(taddr + 7);
    tick();
    bus.rd_en = 1'b0;
    chk("ign_rd_last", bus.rd_data, pat(trig_k + 7));
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk_st("done_trig", 3'b001);
    chk("done_rd_hold", bus.rd_data, pat(trig_k + 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
